top_module_uart: RTL and testbench
==================================

Name: top_module_uart

Overview:
- Memory-mapped UART peripheral: a 32-bit register bus interface plus an 8N1 transmitter/receiver.
- Register set: one control register and a 2-entry data register file. Entry 0 holds the TX byte; entry 1 holds the RX byte.
- Software writes a byte, then sets the send bit. Hardware serialises the byte on tx, deserialises rx, stores the received byte and flags new_rx.
- Intended for loopback testing (tx tied to rx) and for a CPU-side bus.

Parameters:
- CLK_FREQ, 10_000_000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate. Clocks per bit = CLK_FREQ/BAUD, truncated (86).

Ports:
- clk_10MHz  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_pi  in  1  register write strobe, sampled on clock edge.
- reg_sel_pi  in  1  0 = control register, 1 = data register file.
- input_pi  in  32  write data.
- addr_pi  in  1  data register index (ignored when reg_sel_pi=0).
- rx  in  1  serial input, idle high.
- output_po  out  32  read data, combinational.
- tx  out  1  serial output, idle high.

Behaviour:
- Reset, synchronous on rst=1:
  - control = 0, data[0] = 0, data[1] = 0.
  - tx = 1; TX and RX FSMs return to IDLE.
  - A reset mid-frame aborts the frame.
- Read path: output_po = reg_sel_pi ? data[addr_pi] : control. Purely combinational, so a write is visible on the cycle after the write edge.
- Control register bits:
  - bit0 send: software-set; hardware-cleared.
  - bit1 new_rx: hardware-set; software-cleared by writing 0.
  - bits 31:2: write-ignored, read 0.
- Data writes:
  - wr_pi=1 with reg_sel_pi=1 and addr_pi=0 stores the full 32 bits of input_pi into data[0].
  - data[1] is read-only from the bus; writes to it are ignored.
- Control writes: wr_pi=1 with reg_sel_pi=0 loads bits 1:0 from input_pi.
- Same-cycle conflicts: hardware updates (send clear, new_rx set) take priority over a software write in that cycle.
- TX FSM, states IDLE → START → DATA → STOP → IDLE:
  - In IDLE with send=1: latch data[0][7:0], clear send on that edge, enter START.
  - START: drive 0 for one bit time.
  - DATA: drive 8 bits LSB first, one bit time each.
  - STOP: drive 1 for one bit time, then return to IDLE.
  - send=1 written while TX is busy stays pending and is serviced on return to IDLE.
- RX FSM, states IDLE → START → DATA → STOP:
  - rx passes through a 2-flop synchroniser.
  - Falling edge in IDLE enters START. At mid-bit, rx=1 is a false start → IDLE.
  - DATA: sample each data bit at mid-bit, LSB first.
  - STOP: sample at mid-bit.
  - After the stop bit, assert internal rx_data_rdy for exactly one cycle. On that edge, data[1] = {24'b0, byte} and control bit1 = 1; both are visible from the next cycle.
  - A frame with stop bit = 0 is discarded: no rx_data_rdy, no register update.
- Ordering in loopback: send is cleared at TX start, so control reads 0 on the rx_data_rdy cycle (before new_rx is set) and 2 one cycle later.
- New frame while new_rx=1: data[1] is overwritten and new_rx stays 1.
- Hierarchy for bench probing:
  - Serial core instance UART with 1-bit signal rx_data_rdy.
  - Register file instance DATA_REG with array rf_r[0:1] of 32 bits.

Test Plan:
- Reset state: assert rst, then release. Read data0, data1 and control → all 0x00000000; tx = 1.
- Data write: write 0x000000AA to data0, then read data0 → 0xAA. Read data1 → 0x0 (unchanged). A write to data1 has no effect.
- Loopback frame 1 (tx→rx): data0 = 0xAA, control = 0x1.
  - Control reads 0x1 on the next cycle.
  - At the rx_data_rdy pulse, control = 0x0.
  - One cycle later, control = 0x2 and data1 = 0x000000AA, all within ~1 frame (≈870 cycles).
- Loopback frame 2: after 150 µs, data0 = 0x8C, send. data1 reads 0xAA before completion and 0x0000008C after rx_data_rdy; control = 0x2 again.
- Framing error: drive rx with stop bit = 0 → no rx_data_rdy; data1 and new_rx unchanged. False start (glitch shorter than half a bit) → ignored.
- Conflict/reset: software write of 0 to control in the same cycle as rx_data_rdy → control = 0x2. Assert rst mid-frame → tx = 1, all registers 0, no rx_data_rdy.

Source files
------------

// File: rtl/top_module_uart.sv
// ----------------------------------------------------------------------------
// top_module_uart -- memory-mapped 8N1 UART peripheral.
//
// Software writes the TX byte into data register 0 and sets control.send.
// The transmitter serialises the byte on tx. The receiver deserialises rx,
// stores the byte in data register 1 and raises control.new_rx.
//
// Ports:
//   clk_10MHz   system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   wr_pi       register write strobe
//   reg_sel_pi  0 = control register, 1 = data register file
//   input_pi    32-bit write data
//   addr_pi     data register index (ignored for control accesses)
//   rx          serial input, idle high
//   output_po   32-bit combinational read data
//   tx          serial output, idle high
//
// Control register: bit0 send (software-set, hardware-cleared),
//                   bit1 new_rx (hardware-set, software-cleared),
//                   bits 31:2 read as zero.
// ----------------------------------------------------------------------------

// Serial core: one TX FSM and one RX FSM, each sharing the same bit time.
//   send/tx_byte  request and byte from the register side
//   tx_start      one-cycle pulse when a byte is accepted (clears send)
//   rx_data_rdy   one-cycle pulse when a frame with a valid stop bit arrives
//   rx_byte       last received byte, valid when rx_data_rdy is high
module uart_core #(
   parameter int CLK_FREQ = 10_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send,
   input  logic [7:0] tx_byte,
   input  logic       rx,
   output logic       tx,
   output logic       tx_start,
   output logic       rx_data_rdy,
   output logic [7:0] rx_byte
);

   localparam int CPB   = CLK_FREQ / BAUD;
   localparam int CNT_W = $clog2(CPB);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           tx_state;
   logic [CNT_W-1:0] tx_cnt;
   logic [2:0]       tx_bit;
   logic [7:0]       tx_shift;

   state_t           rx_state;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_shift;
   logic             rx_meta;
   logic             rx_sync;
   logic             rx_prev;

   // Accepting a byte is visible to the register side on the same edge.
   assign tx_start = (tx_state == IDLE) && send;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values and simulation matches the synthesised flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx       <= 1'b1;
      end else begin
         case (tx_state)
            IDLE: begin
               tx <= 1'b1;
               if (send) begin
                  tx_shift <= tx_byte;
                  tx_cnt   <= '0;
                  tx       <= 1'b0;
                  tx_state <= START;
               end
            end
            START: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx       <= tx_shift[0];
                  tx_state <= DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx       <= 1'b1;
                     tx_state <= STOP;
                  end else begin
                     tx_bit   <= tx_bit + 1'b1;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx       <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            STOP: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= IDLE;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

   // Receiver: rx is re-timed by two flops; rx_prev gives the falling-edge
   // detector. The start bit is re-checked half a bit later, then every
   // following bit is sampled one full bit time apart (mid-bit).
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta     <= 1'b1;
         rx_sync     <= 1'b1;
         rx_prev     <= 1'b1;
         rx_state    <= IDLE;
         rx_cnt      <= '0;
         rx_bit      <= '0;
         rx_shift    <= '0;
         rx_byte     <= '0;
         rx_data_rdy <= 1'b0;
      end else begin
         rx_meta     <= rx;
         rx_sync     <= rx_meta;
         rx_prev     <= rx_sync;
         rx_data_rdy <= 1'b0;
         case (rx_state)
            IDLE: begin
               if (rx_prev && !rx_sync) begin
                  rx_cnt   <= '0;
                  rx_state <= START;
               end
            end
            START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt <= '0;
                  if (rx_sync) begin
                     rx_state <= IDLE;            // glitch, not a start bit
                  end else begin
                     rx_bit   <= '0;
                     rx_state <= DATA;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  if (rx_bit == 3'd7) begin
                     rx_state <= STOP;
                  end else begin
                     rx_bit <= rx_bit + 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= IDLE;
                  if (rx_sync) begin                // framing error drops the byte
                     rx_byte     <= rx_shift;
                     rx_data_rdy <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= IDLE;
         endcase
      end
   end

endmodule

// Data register file: entry 0 is bus-written (TX byte), entry 1 is loaded
// only by the receiver (RX byte).
module uart_data_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_tx,
   input  logic [31:0] wr_data,
   input  logic        rx_load,
   input  logic [7:0]  rx_byte,
   input  logic        addr,
   output logic [31:0] rd_data,
   output logic [7:0]  tx_byte
);

   logic [31:0] rf_r [0:1];

   // NOTE: this small array is reset explicitly because both entries must
   // read as zero after reset; large RAM arrays would normally be left unreset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_r[0] <= '0;
         rf_r[1] <= '0;
      end else begin
         if (wr_tx) begin
            rf_r[0] <= wr_data;
         end
         if (rx_load) begin
            rf_r[1] <= {24'b0, rx_byte};
         end
      end
   end

   assign rd_data = rf_r[addr];
   assign tx_byte = rf_r[0][7:0];

endmodule

module top_module_uart #(
   parameter int CLK_FREQ = 10_000_000,
   parameter int BAUD     = 115200
) (
   input  logic        clk_10MHz,
   input  logic        rst,
   input  logic        wr_pi,
   input  logic        reg_sel_pi,
   input  logic [31:0] input_pi,
   input  logic        addr_pi,
   input  logic        rx,
   output logic [31:0] output_po,
   output logic        tx
);

   logic [1:0]  ctrl_r;
   logic        wr_ctrl;
   logic        wr_data0;
   logic        tx_start;
   logic        rx_data_rdy;
   logic [7:0]  rx_byte;
   logic [7:0]  tx_byte;
   logic [31:0] rf_rd;

   assign wr_ctrl  = wr_pi && !reg_sel_pi;
   assign wr_data0 = wr_pi && reg_sel_pi && !addr_pi;

   uart_core #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) UART (
      .clk         (clk_10MHz),
      .rst         (rst),
      .send        (ctrl_r[0]),
      .tx_byte     (tx_byte),
      .rx          (rx),
      .tx          (tx),
      .tx_start    (tx_start),
      .rx_data_rdy (rx_data_rdy),
      .rx_byte     (rx_byte)
   );

   uart_data_reg DATA_REG (
      .clk     (clk_10MHz),
      .rst     (rst),
      .wr_tx   (wr_data0),
      .wr_data (input_pi),
      .rx_load (rx_data_rdy),
      .rx_byte (rx_byte),
      .addr    (addr_pi),
      .rd_data (rf_rd),
      .tx_byte (tx_byte)
   );

   // Hardware events win over a software write landing on the same edge.
   always_ff @(posedge clk_10MHz) begin
      if (rst) begin
         ctrl_r <= '0;
      end else begin
         if (tx_start) begin
            ctrl_r[0] <= 1'b0;
         end else if (wr_ctrl) begin
            ctrl_r[0] <= input_pi[0];
         end
         if (rx_data_rdy) begin
            ctrl_r[1] <= 1'b1;
         end else if (wr_ctrl) begin
            ctrl_r[1] <= input_pi[1];
         end
      end
   end

   // NOTE: the output gets a default before any branch so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      output_po = '0;
      if (reg_sel_pi) begin
         output_po = rf_rd;
      end else begin
         output_po = {30'b0, ctrl_r};
      end
   end

endmodule

// File: tb/tb_top_module_uart.sv
`timescale 1ns/1ps
// Scoreboard bench for top_module_uart. Expected TX frames and RX results are
// queued when stimulus is issued; independent monitors consume them.
module tb_top_module_uart;

   localparam int CPB = 10_000_000 / 115200;   // 86 clocks per bit

   logic        clk_10MHz = 1'b0;
   logic        rst;
   logic        wr_pi;
   logic        reg_sel_pi;
   logic [31:0] input_pi;
   logic        addr_pi;
   logic [31:0] output_po;
   logic        tx;
   logic        rx_drv;
   logic        loop_en;
   logic        rx_line;

   always #50 clk_10MHz = ~clk_10MHz;

   assign rx_line = loop_en ? tx : rx_drv;

   top_module_uart dut (
      .clk_10MHz  (clk_10MHz),
      .rst        (rst),
      .wr_pi      (wr_pi),
      .reg_sel_pi (reg_sel_pi),
      .input_pi   (input_pi),
      .addr_pi    (addr_pi),
      .rx         (rx_line),
      .output_po  (output_po),
      .tx         (tx)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       newrx_before;   // expected control.new_rx during the rdy cycle
   } rx_exp_t;

   logic [7:0] tx_q [$];
   rx_exp_t    rx_q [$];
   int         epoch = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   logic       model_newrx = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- monitors ----------------
   // RX side: on every rx_data_rdy pulse pop one expected result.
   initial begin : rx_monitor
      rx_exp_t e;
      forever begin
         @(negedge clk_10MHz);
         if (dut.UART.rx_data_rdy === 1'b1) begin
            if (rx_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_rx_data_rdy at %0t: got pulse expected none", $time);
            end else begin
               e = rx_q.pop_front();
               check("ctrl_at_rdy", output_po, {30'b0, e.newrx_before, 1'b0});
               model_newrx = 1'b1;
               @(negedge clk_10MHz);
               check("ctrl_after_rdy", output_po, 32'h2);
               check("data1_after_rdy", dut.DATA_REG.rf_r[1], {24'b0, e.data});
            end
         end
      end
   end

   // TX side: every sample of a 10-bit frame must equal the ideal waveform.
   initial begin : tx_monitor
      logic       prev;
      logic [7:0] e;
      logic [9:0] frame;
      int         bad;
      int         ep;
      prev = 1'b1;
      forever begin
         @(negedge clk_10MHz);
         if (prev === 1'b1 && tx === 1'b0) begin
            ep  = epoch;
            bad = 0;
            if (tx_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_tx_frame at %0t: got start bit expected idle", $time);
               e = 8'h00;
            end else begin
               e = tx_q[0];
            end
            frame = {1'b1, e, 1'b0};
            for (int i = 0; i < 10 * CPB; i++) begin
               if (i > 0) @(negedge clk_10MHz);
               if (tx !== frame[i / CPB]) bad++;
            end
            if (ep == epoch && tx_q.size() != 0) begin
               e = tx_q.pop_front();
               check("tx_frame_bad_samples", bad, 0);
            end
         end
         prev = tx;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic bus_write(input logic sel, input logic addr, input logic [31:0] data);
      @(negedge clk_10MHz);
      wr_pi      = 1'b1;
      reg_sel_pi = sel;
      addr_pi    = addr;
      input_pi   = data;
      @(negedge clk_10MHz);
      wr_pi      = 1'b0;
      reg_sel_pi = 1'b0;
      addr_pi    = 1'b0;
   endtask

   task automatic bus_read(input logic sel, input logic addr, output logic [31:0] data);
      #2;
      reg_sel_pi = sel;
      addr_pi    = addr;
      #1;
      data       = output_po;
      reg_sel_pi = 1'b0;
      addr_pi    = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while ((rx_q.size() != 0 || tx_q.size() != 0) && n < budget) begin
         @(negedge clk_10MHz);
         n++;
      end
      check(name, rx_q.size() + tx_q.size(), 0);
      rx_q.delete();
      tx_q.delete();
      repeat (3) @(negedge clk_10MHz);
   endtask

   task automatic send_loop(input logic [7:0] b, input logic keep);
      logic [31:0] w;
      w       = $urandom;
      w[7:0]  = b;
      loop_en = 1'b1;
      bus_write(1'b1, 1'b0, w);
      tx_q.push_back(b);
      rx_q.push_back('{data: b, newrx_before: keep});
      bus_write(1'b0, 1'b0, {30'b0, keep, 1'b1});
      model_newrx = keep;
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop);
      for (int i = 0; i < 10; i++) begin
         if (i == 0)      rx_drv = 1'b0;
         else if (i == 9) rx_drv = stop;
         else             rx_drv = b[i-1];
         repeat (CPB) @(negedge clk_10MHz);
      end
      rx_drv = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      logic [31:0] r;
      logic [7:0]  b;
      logic        keep;
      logic        found;
      int          n;
      int          low_cnt;

      rst = 1'b1; wr_pi = 1'b0; reg_sel_pi = 1'b0; addr_pi = 1'b0;
      input_pi = '0; rx_drv = 1'b1; loop_en = 1'b1;
      repeat (3) @(negedge clk_10MHz);
      rst = 1'b0;
      @(negedge clk_10MHz);

      // reset state
      bus_read(1'b1, 1'b0, r); check("reset_data0", r, 32'h0);
      bus_read(1'b1, 1'b1, r); check("reset_data1", r, 32'h0);
      bus_read(1'b0, 1'b0, r); check("reset_ctrl", r, 32'h0);
      check("reset_tx", {31'b0, tx}, 32'h1);

      // data / control register writes
      bus_write(1'b1, 1'b0, 32'hDEAD_BEEF);
      bus_read(1'b1, 1'b0, r); check("data0_full_word", r, 32'hDEAD_BEEF);
      bus_write(1'b1, 1'b0, 32'h0000_00AA);
      bus_read(1'b1, 1'b0, r); check("data0_aa", r, 32'h0000_00AA);
      bus_read(1'b1, 1'b1, r); check("data1_untouched", r, 32'h0);
      bus_write(1'b1, 1'b1, 32'h1234_5678);
      bus_read(1'b1, 1'b1, r); check("data1_write_ignored", r, 32'h0);
      bus_read(1'b1, 1'b0, r); check("data0_after_data1_write", r, 32'h0000_00AA);
      bus_write(1'b0, 1'b0, 32'hFFFF_FFFE);
      bus_read(1'b0, 1'b0, r); check("ctrl_upper_bits_zero", r, 32'h2);
      bus_write(1'b0, 1'b0, 32'h0);
      bus_read(1'b0, 1'b0, r); check("ctrl_cleared", r, 32'h0);
      model_newrx = 1'b0;

      // loopback frame 1
      send_loop(8'hAA, 1'b0);
      bus_read(1'b0, 1'b0, r); check("frame1_send_set", r, 32'h1);
      @(negedge clk_10MHz);
      bus_read(1'b0, 1'b0, r); check("frame1_send_cleared", r, 32'h0);
      wait_done("frame1_done", 1200);
      bus_read(1'b1, 1'b1, r); check("frame1_data1", r, 32'h0000_00AA);
      bus_read(1'b0, 1'b0, r); check("frame1_ctrl", r, 32'h2);

      // loopback frame 2, new_rx left set while the frame arrives
      repeat (600) @(negedge clk_10MHz);
      send_loop(8'h8C, 1'b1);
      bus_read(1'b0, 1'b0, r); check("frame2_send_set", r, 32'h3);
      repeat (200) @(negedge clk_10MHz);
      bus_read(1'b1, 1'b1, r); check("frame2_data1_before", r, 32'h0000_00AA);
      wait_done("frame2_done", 1200);
      bus_read(1'b1, 1'b1, r); check("frame2_data1", r, 32'h0000_008C);
      bus_read(1'b0, 1'b0, r); check("frame2_ctrl", r, 32'h2);

      // framing error: stop bit 0 must be discarded
      loop_en = 1'b0;
      bus_write(1'b0, 1'b0, 32'h0);
      model_newrx = 1'b0;
      drive_frame(8'h3C, 1'b0);
      repeat (2 * CPB) @(negedge clk_10MHz);
      bus_read(1'b1, 1'b1, r); check("framing_err_data1", r, 32'h0000_008C);
      bus_read(1'b0, 1'b0, r); check("framing_err_ctrl", r, 32'h0);

      // false start: glitch shorter than half a bit
      rx_drv = 1'b0;
      repeat (CPB / 2 - 10) @(negedge clk_10MHz);
      rx_drv = 1'b1;
      repeat (2 * CPB) @(negedge clk_10MHz);
      bus_read(1'b1, 1'b1, r); check("false_start_data1", r, 32'h0000_008C);
      bus_read(1'b0, 1'b0, r); check("false_start_ctrl", r, 32'h0);

      // randomized frames, loopback or bench-driven
      for (int k = 0; k < 8; k++) begin
         b    = 8'($urandom);
         keep = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            send_loop(b, keep);
         end else begin
            loop_en = 1'b0;
            bus_write(1'b0, 1'b0, {30'b0, keep, 1'b0});
            model_newrx = keep;
            rx_q.push_back('{data: b, newrx_before: keep});
            drive_frame(b, 1'b1);
         end
         wait_done("rand_frame_done", 1200);
         bus_read(1'b1, 1'b1, r); check("rand_data1", r, {24'b0, b});
         bus_read(1'b0, 1'b0, r); check("rand_ctrl", r, {30'b0, model_newrx, 1'b0});
      end

      // software clear of control colliding with rx_data_rdy
      bus_write(1'b0, 1'b0, 32'h0);
      model_newrx = 1'b0;
      send_loop(8'h96, 1'b0);
      n = 0;
      while (dut.UART.rx_data_rdy !== 1'b1 && n < 1200) begin
         @(negedge clk_10MHz);
         n++;
      end
      found      = (n < 1200);
      wr_pi      = 1'b1;
      reg_sel_pi = 1'b0;
      input_pi   = 32'h0;
      @(negedge clk_10MHz);
      wr_pi = 1'b0;
      check("conflict_pulse_found", {31'b0, found}, 32'h1);
      bus_read(1'b0, 1'b0, r); check("conflict_ctrl", r, 32'h2);
      wait_done("conflict_done", 1200);

      // reset in the middle of a loopback frame
      bus_write(1'b0, 1'b0, 32'h0);
      model_newrx = 1'b0;
      send_loop(8'hC3, 1'b0);
      repeat (300) @(negedge clk_10MHz);
      rst = 1'b1;
      epoch++;
      tx_q.delete();
      rx_q.delete();
      repeat (2) @(negedge clk_10MHz);
      check("tx_during_reset", {31'b0, tx}, 32'h1);
      rst = 1'b0;
      @(negedge clk_10MHz);
      bus_read(1'b1, 1'b0, r); check("midreset_data0", r, 32'h0);
      bus_read(1'b1, 1'b1, r); check("midreset_data1", r, 32'h0);
      bus_read(1'b0, 1'b0, r); check("midreset_ctrl", r, 32'h0);
      low_cnt = 0;
      repeat (1000) begin
         @(negedge clk_10MHz);
         if (tx !== 1'b1) low_cnt++;
      end
      check("tx_idle_after_reset", low_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #20_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
